// File: rtl/path_switch_mux.sv
// path_switch_mux
//   Registered NUM_CH x NUM_CH audio path switch. Each output channel selects
//   any input channel through its field of the active route. A route change
//   is requested with a single-cycle pulse. The change only takes effect after
//   MUTE_SAMPLES all-zero valid samples, so the sinks never see a splice in
//   the middle of a stream.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_valid      one sample per channel is present on i_data
//   i_data       input channel k at [k*VALUE_WIDTH +: VALUE_WIDTH]
//   i_route      requested route; field k is the input index for output k
//   i_route_req  single-cycle route change request
//   o_busy       a route change is pending (mute window active)
//   o_route_ack  one-cycle pulse in the first cycle the new route is active
//   o_route      currently active route
//   o_valid      registered copy of i_valid
//   o_data       routed or muted samples
module path_switch_mux #(
    parameter int VALUE_WIDTH  = 17,
    parameter int NUM_CH       = 4,
    parameter int SEL_WIDTH    = $clog2(NUM_CH),
    parameter int MUTE_SAMPLES = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_valid,
    input  logic [NUM_CH*VALUE_WIDTH-1:0]   i_data,
    input  logic [NUM_CH*SEL_WIDTH-1:0]     i_route,
    input  logic                            i_route_req,
    output logic                            o_busy,
    output logic                            o_route_ack,
    output logic [NUM_CH*SEL_WIDTH-1:0]     o_route,
    output logic                            o_valid,
    output logic [NUM_CH*VALUE_WIDTH-1:0]   o_data
);

    localparam int DW = NUM_CH * VALUE_WIDTH;
    localparam int RW = NUM_CH * SEL_WIDTH;

    // Counter value of the last muted sample; unused when MUTE_SAMPLES is 0.
    localparam logic [7:0] CNT_LAST = 8'(MUTE_SAMPLES - 1);

    function automatic logic [RW-1:0] identity_route();
        logic [RW-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            r[k*SEL_WIDTH +: SEL_WIDTH] = SEL_WIDTH'(k);
        end
        return r;
    endfunction

    localparam logic [RW-1:0] ID_ROUTE = identity_route();

    typedef enum logic {
        RUN,
        MUTE
    } state_t;

    state_t         state_q, state_d;
    logic [RW-1:0]  pend_q, pend_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [RW-1:0]  route_d;
    logic           busy_d;
    logic           ack_d;
    logic           valid_d;
    logic [DW-1:0]  data_d;
    logic [DW-1:0]  routed;

    // Crossbar through the active route. A field that points past the last
    // channel (only possible for non power-of-two NUM_CH) yields silence.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_route
        logic [SEL_WIDTH-1:0] sel;
        assign sel = o_route[k*SEL_WIDTH +: SEL_WIDTH];
        assign routed[k*VALUE_WIDTH +: VALUE_WIDTH] =
            (32'(sel) < NUM_CH) ? i_data[32'(sel)*VALUE_WIDTH +: VALUE_WIDTH] : '0;
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        route_d = o_route;
        busy_d  = o_busy;
        ack_d   = 1'b0;
        valid_d = i_valid;
        data_d  = o_data;

        unique case (state_q)
            RUN: begin
                // The sample arriving alongside a request still uses the old
                // route; muting begins with the following valid sample.
                if (i_valid) begin
                    data_d = routed;
                end
                if (i_route_req) begin
                    if (MUTE_SAMPLES == 0) begin
                        route_d = i_route;
                        ack_d   = 1'b1;
                    end else begin
                        pend_d  = i_route;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = MUTE;
                    end
                end
            end
            MUTE: begin
                // Requests are ignored here; only valid samples advance.
                if (i_valid) begin
                    data_d = '0;
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == CNT_LAST) begin
                        route_d = pend_q;
                        ack_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= RUN;
            pend_q      <= ID_ROUTE;
            cnt_q       <= '0;
            o_route     <= ID_ROUTE;
            o_busy      <= 1'b0;
            o_route_ack <= 1'b0;
            o_valid     <= 1'b0;
            o_data      <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            o_route     <= route_d;
            o_busy      <= busy_d;
            o_route_ack <= ack_d;
            o_valid     <= valid_d;
            o_data      <= data_d;
        end
    end

endmodule

// File: tb/tb_path_switch_mux.sv
// tb_path_switch_mux
//   Directed bench for path_switch_mux with two instances: one with a
//   four-sample mute window and one with no mute window. Expected output
//   samples are queued as stimulus is driven and popped by a monitor that
//   samples on the falling clock edge.
module tb_path_switch_mux;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_valid, a_req, a_busy, a_ack, a_ovalid;
    logic [67:0] a_data, a_odata;
    logic [7:0]  a_route, a_route_o;
    logic        b_valid, b_req, b_busy, b_ack, b_ovalid;
    logic [67:0] b_data, b_odata;
    logic [7:0]  b_route, b_route_o;

    path_switch_mux #(.VALUE_WIDTH(17), .NUM_CH(4), .MUTE_SAMPLES(4)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_valid), .i_data(a_data),
        .i_route(a_route), .i_route_req(a_req), .o_busy(a_busy),
        .o_route_ack(a_ack), .o_route(a_route_o), .o_valid(a_ovalid),
        .o_data(a_odata)
    );

    path_switch_mux #(.VALUE_WIDTH(17), .NUM_CH(4), .MUTE_SAMPLES(0)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .i_data(b_data),
        .i_route(b_route), .i_route_req(b_req), .o_busy(b_busy),
        .o_route_ack(b_ack), .o_route(b_route_o), .o_valid(b_ovalid),
        .o_data(b_odata)
    );

    function automatic logic [67:0] pk(input logic [16:0] c0, input logic [16:0] c1,
                                       input logic [16:0] c2, input logic [16:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    function automatic logic [7:0] rt(input logic [1:0] r0, input logic [1:0] r1,
                                      input logic [1:0] r2, input logic [1:0] r3);
        return {r3, r2, r1, r0};
    endfunction

    logic [67:0] D, SWP, FAN, Z;
    logic [7:0]  ID, SWR, FANR;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rc;
    int acks0;
    int a_acks = 0;
    int a_ack_cyc = -1;
    int b_acks = 0;
    logic b_busy_seen = 1'b0;
    logic [67:0] qa[$];
    logic [67:0] qb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected sample per presented output sample.
    always @(negedge clk) begin
        if (a_ovalid === 1'b1) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_sample: got %h expected none", a_odata);
            end else begin
                check("a_data", a_odata, qa.pop_front());
            end
        end
        if (b_ovalid === 1'b1) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_sample: got %h expected none", b_odata);
            end else begin
                check("b_data", b_odata, qb.pop_front());
            end
        end
        if (a_ack === 1'b1) begin
            a_acks++;
            a_ack_cyc = cyc;
        end
        if (b_ack === 1'b1) b_acks++;
        if (b_busy === 1'b1) b_busy_seen = 1'b1;
    end

    task automatic step_a(input logic v, input logic [67:0] d, input logic req,
                          input logic [7:0] r, input logic [67:0] exp);
        a_valid = v;
        a_data  = d;
        a_req   = req;
        a_route = r;
        if (v) qa.push_back(exp);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        a_req   = 1'b0;
    endtask

    task automatic step_b(input logic v, input logic [67:0] d, input logic req,
                          input logic [7:0] r, input logic [67:0] exp);
        b_valid = v;
        b_data  = d;
        b_req   = req;
        b_route = r;
        if (v) qb.push_back(exp);
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        b_req   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        D    = pk(17'h0ABAB, 17'h0CDCD, 17'h11111, 17'h02222);
        SWP  = pk(17'h0CDCD, 17'h0ABAB, 17'h02222, 17'h11111);
        FAN  = pk(17'h11111, 17'h11111, 17'h11111, 17'h11111);
        Z    = '0;
        ID   = rt(2'd0, 2'd1, 2'd2, 2'd3);
        SWR  = rt(2'd1, 2'd0, 2'd3, 2'd2);
        FANR = rt(2'd2, 2'd2, 2'd2, 2'd2);
        a_valid = 1'b0; a_req = 1'b0; a_data = '0; a_route = '0;
        b_valid = 1'b0; b_req = 1'b0; b_data = '0; b_route = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", a_ovalid, 1'b0);
        check("rst_data", a_odata, Z);
        check("rst_route", a_route_o, ID);
        check("rst_busy", a_busy, 1'b0);
        check("rst_ack", a_ack, 1'b0);
        rst_n = 1'b1;

        // Identity routing
        step_a(1'b1, D, 1'b0, '0, D);
        step_a(1'b1, D, 1'b0, '0, D);
        check("id_route", a_route_o, ID);
        check("id_busy", a_busy, 1'b0);

        // Swap with continuous valid: request-cycle sample unmuted, then 4 zeros
        acks0 = a_acks;
        rc = cyc;
        step_a(1'b1, D, 1'b1, SWR, D);
        check("swap_busy_rise", a_busy, 1'b1);
        check("swap_route_held", a_route_o, ID);
        repeat (4) step_a(1'b1, D, 1'b0, '0, Z);
        check("swap_ack", a_ack, 1'b1);
        check("swap_route", a_route_o, SWR);
        check("swap_busy_fall", a_busy, 1'b0);
        step_a(1'b1, D, 1'b0, '0, SWP);
        check("swap_ack_pulse", a_ack, 1'b0);
        step_a(1'b1, D, 1'b0, '0, SWP);
        check("swap_ack_count", a_acks - acks0, 1);
        check("swap_ack_cycle", a_ack_cyc, rc + 5);

        // Gapped valid: valid every third cycle, back to identity
        rc = cyc;
        step_a(1'b1, D, 1'b1, ID, SWP);
        for (int i = 0; i < 4; i++) begin
            step_a(1'b0, D, 1'b0, '0, Z);
            if (i == 1) begin
                check("gap_valid_low", a_ovalid, 1'b0);
                check("gap_data_hold", a_odata, Z);
                check("gap_busy", a_busy, 1'b1);
            end
            step_a(1'b0, D, 1'b0, '0, Z);
            step_a(1'b1, D, 1'b0, '0, Z);
        end
        check("gap_ack", a_ack, 1'b1);
        check("gap_route", a_route_o, ID);
        step_a(1'b1, D, 1'b0, '0, D);
        check("gap_ack_cycle", a_ack_cyc, rc + 13);

        // Second request during the mute window is ignored
        acks0 = a_acks;
        step_a(1'b1, D, 1'b1, SWR, D);
        step_a(1'b1, D, 1'b1, rt(2'd3, 2'd3, 2'd3, 2'd3), Z);
        repeat (3) step_a(1'b1, D, 1'b0, '0, Z);
        check("ign_ack", a_ack, 1'b1);
        check("ign_route", a_route_o, SWR);
        step_a(1'b1, D, 1'b0, '0, SWP);
        repeat (3) step_a(1'b0, D, 1'b0, '0, Z);
        check("ign_ack_count", a_acks - acks0, 1);
        check("ign_route_final", a_route_o, SWR);

        // Reset after two muted samples discards the pending route
        acks0 = a_acks;
        step_a(1'b1, D, 1'b1, rt(2'd3, 2'd2, 2'd1, 2'd0), SWP);
        step_a(1'b1, D, 1'b0, '0, Z);
        step_a(1'b1, D, 1'b0, '0, Z);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", a_ovalid, 1'b0);
        check("mid_rst_data", a_odata, Z);
        check("mid_rst_route", a_route_o, ID);
        check("mid_rst_busy", a_busy, 1'b0);
        check("mid_rst_ack", a_ack, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) step_a(1'b0, D, 1'b0, '0, Z);
        check("post_rst_no_ack", a_acks - acks0, 0);
        check("post_rst_route", a_route_o, ID);
        check("post_rst_busy", a_busy, 1'b0);
        step_a(1'b1, D, 1'b0, '0, D);

        // No mute window, fan-out of input 2 to every output
        step_b(1'b1, D, 1'b0, '0, D);
        step_b(1'b1, D, 1'b1, FANR, D);
        check("m0_ack", b_ack, 1'b1);
        check("m0_route", b_route_o, FANR);
        check("m0_busy", b_busy, 1'b0);
        step_b(1'b1, D, 1'b0, '0, FAN);
        check("m0_ack_pulse", b_ack, 1'b0);
        step_b(1'b0, D, 1'b0, '0, Z);
        check("m0_ack_count", b_acks, 1);
        check("m0_busy_never", b_busy_seen, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
